// File: rtl/hit_map_readout_pkg.sv
// rtl/hit_map_readout_pkg.sv - shared state type, default widths and width helpers for hit map readout
package hit_map_readout_pkg;

  localparam int SSIDBITS_DEFAULT       = 8;
  localparam int NCOLS_HIM_DEFAULT      = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT,
    ST_SCAN,
    ST_DONE
  } readout_state_t;

  // Column index width; a one-column map still needs a 1-bit index.
  function automatic int col_bits(input int ncols);
    return (ncols > 1) ? $clog2(ncols) : 1;
  endfunction

  function automatic int cnt_bits(input int ncols);
    return $clog2(ncols + 1);
  endfunction

  function automatic int timer_bits(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/hit_map_readout_lowest_set_bit_encoder.sv
// rtl/hit_map_readout_lowest_set_bit_encoder.sv - combinational lowest-set-bit priority encoder
// Returns the index of the lowest set bit and a flag telling whether any bit is set.
module lowest_set_bit_encoder
  import hit_map_readout_pkg::*;
#(
  parameter int WIDTH   = NCOLS_HIM_DEFAULT,
  parameter int IDXBITS = col_bits(WIDTH)
) (
  input  logic [WIDTH-1:0]   bits,
  output logic [IDXBITS-1:0] index,
  output logic               any
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) begin
        index = IDXBITS'(i);
      end
    end
  end

  assign any = |bits;

endmodule

// File: rtl/hit_map_readout.sv
// rtl/hit_map_readout.sv - reads hit bitmaps by SSID and streams each set column as one beat
// One storage read per query, bounded wait for the response, then ascending-column serialisation.
module hit_map_readout
  import hit_map_readout_pkg::*;
#(
  parameter int SSIDBITS       = SSIDBITS_DEFAULT,
  parameter int NCOLS_HIM      = NCOLS_HIM_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int COLBITS        = col_bits(NCOLS_HIM),
  parameter int CNTBITS        = cnt_bits(NCOLS_HIM)
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [SSIDBITS-1:0] querySSID,
  input  logic                queryValid,
  output logic                queryReady,
  output logic                readMemory,
  output logic [SSIDBITS-1:0] readSSID,
  input  logic                readReady,
  input  logic [NCOLS_HIM-1:0] hitInfo,
  output logic [SSIDBITS-1:0] outSSID,
  output logic [COLBITS-1:0]  outColumn,
  output logic                outValid,
  input  logic                outReady,
  output logic                queryDone,
  output logic [CNTBITS-1:0]  hitCount,
  output logic                timeoutError
);

  localparam int TOBITS = timer_bits(TIMEOUT_CYCLES);
  localparam logic [TOBITS-1:0] TIMER_LAST = TOBITS'(TIMEOUT_CYCLES - 1);

  readout_state_t state, state_next;

  logic                 running;
  logic [NCOLS_HIM-1:0] map;
  logic [NCOLS_HIM-1:0] map_after_beat;
  logic [TOBITS-1:0]    timer;
  logic [CNTBITS-1:0]   count;
  logic                 timed_out;
  logic [COLBITS-1:0]   low_col;
  logic                 map_any;
  logic                 query_take;
  logic                 beat_taken;

  lowest_set_bit_encoder #(
    .WIDTH   (NCOLS_HIM),
    .IDXBITS (COLBITS)
  ) u_lowest_set_bit_encoder (
    .bits  (map),
    .index (low_col),
    .any   (map_any)
  );

  // Clearing the lowest set bit is exactly the column just handed out.
  assign map_after_beat = map & (map - NCOLS_HIM'(1));

  // running keeps queryReady low while reset is held even though state sits at IDLE.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= 1'b1;
    end
  end

  always_comb begin
    queryReady = running && (state == ST_IDLE);
    readMemory = (state == ST_REQUEST);
    outValid   = (state == ST_SCAN) && map_any;
    queryDone  = (state == ST_DONE);
    outSSID    = outValid ? readSSID : '0;
    outColumn  = outValid ? low_col : '0;
    query_take = queryValid && queryReady;
    beat_taken = outValid && outReady;
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (query_take) state_next = ST_REQUEST;
      end
      ST_REQUEST: state_next = ST_WAIT;
      ST_WAIT: begin
        // A response on the last timer cycle still counts as a response.
        if (readReady) begin
          state_next = (hitInfo == '0) ? ST_DONE : ST_SCAN;
        end else if (timer == TIMER_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_SCAN: begin
        if (beat_taken && (map_after_beat == '0)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      readSSID  <= '0;
      map       <= '0;
      timer     <= '0;
      count     <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (query_take) begin
            readSSID  <= querySSID;
            count     <= '0;
            timed_out <= 1'b0;
          end
        end
        ST_REQUEST: timer <= '0;
        ST_WAIT: begin
          if (readReady) begin
            map <= hitInfo;
          end else begin
            timer <= timer + TOBITS'(1);
            if (timer == TIMER_LAST) timed_out <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (beat_taken) begin
            map   <= map_after_beat;
            count <= count + CNTBITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign hitCount     = count;
  assign timeoutError = timed_out;

endmodule

// File: tb/tb_hit_map_readout.sv
// tb/tb_hit_map_readout.sv - randomized self-checking bench for hit_map_readout
module tb_hit_map_readout;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        resetN;
  logic [7:0]  querySSID;
  logic        queryValid;
  logic        queryReady;
  logic        readMemory;
  logic [7:0]  readSSID;
  logic        readReady;
  logic [15:0] hitInfo;
  logic [7:0]  outSSID;
  logic [3:0]  outColumn;
  logic        outValid;
  logic        outReady;
  logic        queryDone;
  logic [4:0]  hitCount;
  logic        timeoutError;

  int total = 0;
  int bad   = 0;

  hit_map_readout dut (
    .clock        (clock),
    .resetN       (resetN),
    .querySSID    (querySSID),
    .queryValid   (queryValid),
    .queryReady   (queryReady),
    .readMemory   (readMemory),
    .readSSID     (readSSID),
    .readReady    (readReady),
    .hitInfo      (hitInfo),
    .outSSID      (outSSID),
    .outColumn    (outColumn),
    .outValid     (outValid),
    .outReady     (outReady),
    .queryDone    (queryDone),
    .hitCount     (hitCount),
    .timeoutError (timeoutError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, queryReady, 0);
    check({tag, "_rdmem"}, readMemory, 0);
    check({tag, "_rdssid"}, readSSID, 0);
    check({tag, "_valid"}, outValid, 0);
    check({tag, "_ossid"}, outSSID, 0);
    check({tag, "_ocol"}, outColumn, 0);
    check({tag, "_done"}, queryDone, 0);
    check({tag, "_count"}, hitCount, 0);
    check({tag, "_toerr"}, timeoutError, 0);
  endtask

  // Reference: a query yields the set columns of its map in ascending order,
  // a done pulse with their number, or a timeout after TIMEOUT silent wait cycles.
  task automatic run_query(input logic [7:0] ssid, input logic [15:0] map, input int delay,
                           input bit no_response, input bit stall, input bit spurious);
    int exp_cols[$];
    int guard;
    for (int c = 0; c < 16; c++) if (map[c]) exp_cols.push_back(c);
    if (spurious) begin
      readReady = 1'b1;
      hitInfo   = 16'($urandom);
      step;
      readReady = 1'b0;
    end
    check("idle_ready", queryReady, 1);
    querySSID  = ssid;
    queryValid = 1'b1;
    step;
    queryValid = 1'b0;
    querySSID  = 8'($urandom);
    check("read_strobe", readMemory, 1);
    check("read_ssid", readSSID, ssid);
    check("busy_not_ready", queryReady, 0);
    step;
    if (no_response) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        check("wait_no_done", {readMemory, outValid, queryDone}, 0);
        step;
      end
      check("to_done", queryDone, 1);
      check("to_error", timeoutError, 1);
      check("to_count", hitCount, 0);
    end else begin
      for (int i = 0; i < delay; i++) begin
        check("wait_quiet", {readMemory, outValid, queryDone}, 0);
        check("wait_ssid_held", readSSID, ssid);
        step;
      end
      readReady = 1'b1;
      hitInfo   = map;
      step;
      readReady = 1'b0;
      hitInfo   = 16'($urandom);
      if (exp_cols.size() != 0) begin
        guard = 0;
        while (exp_cols.size() > 0 && guard < 400) begin
          outReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          if (spurious) begin
            readReady = 1'($urandom_range(0, 1));
            hitInfo   = 16'($urandom);
          end
          check("beat_valid", outValid, 1);
          check("beat_ssid", outSSID, ssid);
          check("beat_col", outColumn, exp_cols[0]);
          check("beat_no_done", queryDone, 0);
          if (outReady) void'(exp_cols.pop_front());
          guard++;
          step;
        end
        readReady = 1'b0;
        check("beats_left", exp_cols.size(), 0);
      end
      check("done", queryDone, 1);
      check("count", hitCount, $countones(map));
      check("no_timeout", timeoutError, 0);
      check("done_no_valid", outValid, 0);
    end
    outReady = 1'b1;
    step;
    check("done_once", queryDone, 0);
    check("back_idle", queryReady, 1);
  endtask

  initial begin
    resetN     = 1'b0;
    querySSID  = '0;
    queryValid = 1'b0;
    readReady  = 1'b0;
    hitInfo    = '0;
    outReady   = 1'b1;
    step;
    step;
    check_all_zero("reset");
    resetN = 1'b1;
    step;
    check("ready_after_reset", queryReady, 1);

    run_query(8'h05, 16'h0010, 3, 1'b0, 1'b0, 1'b0);
    run_query(8'hA7, 16'h8421, 2, 1'b0, 1'b1, 1'b0);
    run_query(8'h11, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
    run_query(8'h22, 16'h0000, 0, 1'b1, 1'b0, 1'b0);
    run_query(8'h23, 16'h0003, 1, 1'b0, 1'b0, 1'b0);
    run_query(8'h5A, 16'h0F0F, 4, 1'b0, 1'b1, 1'b1);
    run_query(8'h6B, 16'h0101, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
    run_query(8'hFF, 16'hFFFF, 0, 1'b0, 1'b1, 1'b0);

    querySSID  = 8'h3C;
    queryValid = 1'b1;
    step;
    queryValid = 1'b0;
    step;
    readReady = 1'b1;
    hitInfo   = 16'hFFFF;
    step;
    readReady = 1'b0;
    outReady  = 1'b1;
    check("rst_first_beat", outColumn, 0);
    step;
    check("rst_second_beat", outColumn, 1);
    check("rst_second_valid", outValid, 1);
    #1 resetN = 1'b0;
    #1;
    check_all_zero("mid_reset");
    step;
    check("mid_reset_no_done", queryDone, 0);
    check("mid_reset_not_ready", queryReady, 0);
    resetN = 1'b1;
    step;
    check("rst_release_ready", queryReady, 1);
    check("rst_release_no_done", queryDone, 0);
    run_query(8'h3D, 16'h0240, 2, 1'b0, 1'b0, 1'b0);

    for (int q = 0; q < 6; q++) begin
      run_query(8'($urandom), 16'($urandom) & 16'($urandom), $urandom_range(0, 10),
                1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_map_readout.md
# hit_map_readout

Read-side controller for the block-memory hit storage. The write side fills the storage with hit bitmaps indexed by SSID. This block takes SSID queries from downstream logic, issues one read request per query to the storage, and waits for the storage's read-ready response. It then serialises every set column of the returned hit bitmap as one (SSID, column) beat on a valid/ready output stream, and closes each query with a done pulse carrying the hit count.

## Interface
Parameters:
- SSIDBITS, 8, width of an SSID
- NCOLS_HIM, 16, hit-info bitmap width (columns per SSID)
- TIMEOUT_CYCLES, 64, maximum cycles spent waiting for readReady before the query is aborted
- COLBITS, $clog2(NCOLS_HIM), derived; column index width
- CNTBITS, $clog2(NCOLS_HIM+1), derived; hit-count width

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock, rising edge
- resetN  in  1  asynchronous active-low reset
- querySSID  in  SSIDBITS  SSID to read out
- queryValid  in  1  query present
- queryReady  out  1  block accepts a query (IDLE only)
- readMemory  out  1  one-cycle read strobe to storage
- readSSID  out  SSIDBITS  address for readMemory, held until response or timeout
- readReady  in  1  storage response valid (one cycle)
- hitInfo  in  NCOLS_HIM  bitmap returned with readReady
- outSSID  out  SSIDBITS  SSID of current beat
- outColumn  out  COLBITS  column index of current beat
- outValid  out  1  beat valid
- outReady  in  1  consumer accepts beat
- queryDone  out  1  one-cycle end-of-query pulse
- hitCount  out  CNTBITS  beats emitted for the query, valid with queryDone
- timeoutError  out  1  with queryDone: query aborted by timeout

## Operation
- FSM states: IDLE, REQUEST, WAIT, SCAN, DONE.
- IDLE: queryReady=1. When queryValid&queryReady, latch querySSID into readSSID and go to REQUEST.
- REQUEST: readMemory=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: readReady sampled high latches hitInfo into the pending map.
  - Map is zero: go to DONE with hitCount=0.
  - Map is nonzero: go to SCAN.
- WAIT timeout: the counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without readReady, go to DONE with timeoutError=1 and hitCount=0.
- SCAN: outValid=1, outSSID=readSSID, outColumn=index of the lowest set bit of the pending map.
  - On outValid&outReady: clear that bit and increment the count.
  - The map becoming zero on that handshake goes to DONE.
  - Columns are emitted in ascending order.
- DONE: queryDone=1 for one cycle with hitCount and timeoutError valid; go to IDLE.
- readReady outside WAIT is ignored, and hitInfo is not latched.
- A query presented outside IDLE is not accepted, since queryReady=0.

## Timing
- Reset values: every output 0 (queryReady=0 during reset), state IDLE, pending map 0, counters 0. queryReady rises the first cycle after reset release.
- Query accepted at edge N: readMemory high in cycle N+1.
- readReady sampled at edge M:
  - outValid rises in cycle M+1.
  - For a zero map, queryDone is high in cycle M+1.
- Throughput: one beat per cycle while outReady=1. A map with k set bits needs k accepted beats, then queryDone one cycle after the last handshake.
- Minimum query-to-query spacing, zero map with immediate readReady: 4 cycles.
- Output stability: outValid, outSSID and outColumn hold unchanged while outValid&!outReady. outValid never drops without a handshake except on reset.
- Reset asserted mid-query aborts it immediately. No queryDone is issued for the aborted query.
- readReady in the same cycle as the final timeout count: readReady wins and no timeout is flagged.
- hitCount saturates by construction: maximum NCOLS_HIM fits CNTBITS.

## Structure
- Shared package: FSM state enum, the SSIDBITS/NCOLS_HIM defaults already used by storage and address generator, and the COLBITS/CNTBITS derivation functions.
- One sub-module, lowest_set_bit_encoder: a combinational NCOLS_HIM→COLBITS priority encoder with an any-bit flag. It is reusable by future storage scanners.

## Test plan
- Single hit: query SSID 0x05, readReady after 3 cycles with hitInfo 0x0010, outReady=1 → one beat (0x05, col 4), then queryDone with hitCount=1 and timeoutError=0.
- Multiple hits with backpressure: hitInfo 0x8421, outReady toggling 1/0 → beats at cols 0, 5, 10, 15 in order, each held stable while stalled; hitCount=4.
- Empty map: hitInfo 0x0000 → no outValid, queryDone one cycle after readReady, hitCount=0.
- Timeout: readReady never asserted → queryDone after TIMEOUT_CYCLES in WAIT, timeoutError=1, hitCount=0; next query accepted normally.
- Spurious and simultaneous events: readReady pulses in IDLE and SCAN are ignored (beat sequence unchanged); readReady on the final timeout cycle is accepted without timeoutError.
- Reset mid-SCAN: resetN low during the 2nd beat of 0xFFFF → all outputs 0 asynchronously, no queryDone; after release queryReady=1 and a fresh query works.
